// File: rtl/dcache_direct_wb_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, line geometry and address field widths.
package dcache_direct_wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam int WORDW = 32;
  localparam int LINEW = 128;
  localparam int OFFW  = 2;

  // Tag is whatever remains of the word address above offset and index.
  function automatic int tagWidth(input int addrw, input int idxw);
    return addrw - OFFW - idxw;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage with a combinational read by index
// and one registered whole-entry write port.
module dcache_line_array
  import dcache_direct_wb_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDXW  = 3,
  parameter int TAGW  = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDXW-1:0]  rdIdx_i,
  output logic             rdValid_o,
  output logic             rdDirty_o,
  output logic [TAGW-1:0]  rdTag_o,
  output logic [LINEW-1:0] rdData_o,
  input  logic             wrEn_i,
  input  logic [IDXW-1:0]  wrIdx_i,
  input  logic             wrValid_i,
  input  logic             wrDirty_i,
  input  logic [TAGW-1:0]  wrTag_i,
  input  logic [LINEW-1:0] wrData_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [LINEW-1:0] data_q [LINES];

  // Only the status bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIdx_i] <= wrValid_i;
      dirty_q[wrIdx_i] <= wrDirty_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tag_q[wrIdx_i]  <= wrTag_i;
      data_q[wrIdx_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdDirty_o = dirty_q[rdIdx_i];
  assign rdTag_o   = tag_q[rdIdx_i];
  assign rdData_o  = data_q[rdIdx_i];

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a single
// outstanding miss between the core data port and line-wide main memory.
module dcache_direct_wb
  import dcache_direct_wb_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int ADDRW = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             proc_read,
  input  logic             proc_write,
  input  logic [ADDRW-1:0] proc_addr,
  input  logic [WORDW-1:0] proc_wdata,
  output logic             proc_stall,
  output logic [WORDW-1:0] proc_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [ADDRW-3:0] mem_addr,
  output logic [LINEW-1:0] mem_wdata,
  input  logic [LINEW-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = tagWidth(ADDRW, IDXW);

  state_e state_q, state_d;
  logic   memRead_q, memWrite_q;

  logic [OFFW-1:0] off;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;

  logic             lineValid, lineDirty;
  logic [TAGW-1:0]  lineTag;
  logic [LINEW-1:0] lineData;
  logic [WORDS-1:0][WORDW-1:0] lineWords, mergedWords;

  logic             wrEn, wrValid, wrDirty;
  logic [TAGW-1:0]  wrTag;
  logic [LINEW-1:0] wrData;
  logic             hit, req;

  assign off = proc_addr[OFFW-1:0];
  assign idx = proc_addr[OFFW+IDXW-1:OFFW];
  assign tag = proc_addr[ADDRW-1:OFFW+IDXW];

  dcache_line_array #(
    .LINES(LINES),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rdIdx_i  (idx),
    .rdValid_o(lineValid),
    .rdDirty_o(lineDirty),
    .rdTag_o  (lineTag),
    .rdData_o (lineData),
    .wrEn_i   (wrEn),
    .wrIdx_i  (idx),
    .wrValid_i(wrValid),
    .wrDirty_i(wrDirty),
    .wrTag_i  (wrTag),
    .wrData_i (wrData)
  );

  assign lineWords = lineData;
  assign hit       = lineValid && (lineTag == tag);
  assign req       = proc_read || proc_write;

  // Writes to the array default to rewriting the current entry unchanged,
  // so each state only overrides the fields it actually modifies.
  always_comb begin
    state_d          = state_q;
    proc_stall       = 1'b1;
    wrEn             = 1'b0;
    wrValid          = lineValid;
    wrDirty          = lineDirty;
    wrTag            = lineTag;
    wrData           = lineData;
    mergedWords      = lineWords;
    mergedWords[off] = proc_wdata;
    case (state_q)
      IDLE: begin
        proc_stall = req && !hit;
        if (req && hit) begin
          if (proc_write) begin
            wrEn    = 1'b1;
            wrDirty = 1'b1;
            wrData  = mergedWords;
          end
        end else if (req) begin
          state_d = (lineValid && lineDirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          wrEn    = 1'b1;
          wrDirty = 1'b0;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ready) begin
          wrEn    = 1'b1;
          wrValid = 1'b1;
          wrDirty = 1'b0;
          wrTag   = tag;
          wrData  = mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memRead_q  <= (state_d == ALLOCATE);
      memWrite_q <= (state_d == WRITEBACK);
    end
  end

  assign mem_read   = memRead_q;
  assign mem_write  = memWrite_q;
  assign mem_addr   = (state_q == WRITEBACK) ? {lineTag, idx} : proc_addr[ADDRW-1:OFFW];
  assign mem_wdata  = lineData;
  assign proc_rdata = proc_read ? lineWords[off] : '0;

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb: a latency-programmable memory model,
// a reference word store and a queue of expected read data.
module tb_dcache_direct_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  dcache_direct_wb #(.LINES(8), .WORDS(4), .ADDRW(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .proc_read (proc_read),
    .proc_write(proc_write),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_stall(proc_stall),
    .proc_rdata(proc_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int passed = 0;
  int total  = 0;
  int memLatency = 0;
  int memReads = 0;
  int memWrites = 0;
  logic [27:0]  lastRdAddr, lastWrAddr;
  logic [127:0] lastWrData;
  logic [127:0] memArr [int];
  logic [31:0]  refMem [int];
  logic [31:0]  expQ [$];

  bit           inFlight = 1'b0;
  int           waitCnt = 0;
  logic [27:0]  holdAddr;
  logic [127:0] holdData;

  task automatic checkOutput(input string tagName, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tagName, obs, exp);
  endtask

  // Power-on memory image: line 4 is the well-known pattern, others are address-derived.
  function automatic logic [127:0] initLine(input logic [27:0] la);
    logic [127:0] l;
    if (la == 28'h4) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'h5000_0000 + 32'(la) * 32'd16 + 32'(w);
    return l;
  endfunction

  function automatic logic [127:0] memLine(input logic [27:0] la);
    if (memArr.exists(int'(la))) return memArr[int'(la)];
    return initLine(la);
  endfunction

  function automatic logic [31:0] refWord(input logic [29:0] a);
    logic [127:0] l;
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    l = initLine(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  // Memory responder: answers after memLatency wait cycles and watches request stability.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        inFlight = 1'b0;
        waitCnt  = 0;
      end else if (mem_read || mem_write) begin
        checkOutput("memExclusive", {mem_read, mem_write}, (mem_read ? 2'b10 : 2'b01));
        if (!inFlight) begin
          inFlight = 1'b1;
          waitCnt  = 0;
          holdAddr = mem_addr;
          holdData = mem_wdata;
        end else begin
          checkOutput("memAddrStable", mem_addr, holdAddr);
          if (mem_write) checkOutput("memWdataStable", mem_wdata, holdData);
        end
        if (waitCnt >= memLatency) begin
          mem_ready = 1'b1;
          inFlight  = 1'b0;
          if (mem_write) begin
            memArr[int'(mem_addr)] = mem_wdata;
            lastWrAddr = mem_addr;
            lastWrData = mem_wdata;
            memWrites++;
          end else begin
            mem_rdata  = memLine(mem_addr);
            lastRdAddr = mem_addr;
            memReads++;
          end
        end else begin
          waitCnt++;
        end
      end else begin
        inFlight = 1'b0;
      end
    end
  end

  // mode 0 = read, 1 = write, 2 = read and write together.
  task automatic applyStimulus(input int mode, input logic [29:0] a, input logic [31:0] d, output int stalls);
    bit done;
    logic [31:0] e;
    proc_read  = (mode != 1);
    proc_write = (mode != 0);
    proc_addr  = a;
    proc_wdata = d;
    if (mode == 0) expQ.push_back(refWord(a));
    else refMem[int'(a)] = d;
    stalls = 0;
    done   = 1'b0;
    while (!done && stalls <= 100) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
        if (mode == 0) begin
          e = expQ.pop_front();
          checkOutput("readData", proc_rdata, e);
        end else if (mode == 1) begin
          checkOutput("rdataZeroOnWrite", proc_rdata, 0);
        end
      end else begin
        stalls++;
      end
    end
    checkOutput("accessCompleted", done, 1);
    @(posedge clk); #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    proc_read = 1'b0;
    proc_write = 1'b0;
    proc_addr = '0;
    proc_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("resetIdle", {proc_stall, mem_read, mem_write}, 3'b000);
    checkOutput("resetRdataZero", proc_rdata, 0);
    @(posedge clk); #1;

    memLatency = 3;
    applyStimulus(0, 30'h10, 0, s);
    checkOutput("coldMissStalls", s, 5);
    checkOutput("coldMissAddr", lastRdAddr, 28'h4);
    applyStimulus(0, 30'h11, 0, s);
    checkOutput("hitNoStall", s, 0);

    applyStimulus(1, 30'h11, 32'hCAFEF00D, s);
    checkOutput("writeHitNoStall", s, 0);
    applyStimulus(0, 30'h11, 0, s);
    checkOutput("readAfterWriteNoStall", s, 0);
    checkOutput("noWritebackYet", memWrites, 0);

    applyStimulus(0, 30'h31, 0, s);
    checkOutput("dirtyMissStalls", s, 9);
    checkOutput("victimAddr", lastWrAddr, 28'h4);
    checkOutput("victimData", lastWrData, 128'hDDDDDDDD_CCCCCCCC_CAFEF00D_AAAAAAAA);
    checkOutput("fillAddrAfterWb", lastRdAddr, 28'hC);

    applyStimulus(0, 30'h11, 0, s);
    checkOutput("cleanEvictStalls", s, 5);
    applyStimulus(0, 30'h31, 0, s);
    checkOutput("cleanEvictStalls2", s, 5);
    checkOutput("cleanEvictNoWrite", memWrites, 1);

    memLatency = 0;
    applyStimulus(0, 30'h48, 0, s);
    checkOutput("zeroLatencyStalls", s, 2);
    memLatency = 20;
    applyStimulus(0, 30'h8, 0, s);
    checkOutput("longLatencyStalls", s, 22);
    checkOutput("longLatencyAddr", lastRdAddr, 28'h2);

    memLatency = 1;
    applyStimulus(2, 30'h4B, 32'hA5A5F00F, s);
    checkOutput("readWriteMissStalls", s, 3);
    applyStimulus(0, 30'h4B, 0, s);
    checkOutput("readWriteIsWrite", s, 0);
    applyStimulus(0, 30'h48, 0, s);
    checkOutput("neighbourWordHit", s, 0);
    checkOutput("writeCountUnchanged", memWrites, 1);

    memLatency = 30;
    proc_read = 1'b1;
    proc_addr = 30'h50;
    repeat (3) @(negedge clk);
    checkOutput("allocBeforeReset", {proc_stall, mem_read, mem_write}, 3'b110);
    rst = 1'b1;
    proc_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetAbandonsMiss", {proc_stall, mem_read, mem_write}, 3'b000);
    @(posedge clk); #1;
    memLatency = 2;
    applyStimulus(0, 30'h50, 0, s);
    checkOutput("missAfterReset", s, 4);
    applyStimulus(0, 30'h11, 0, s);
    checkOutput("refillWrittenBackLine", s, 4);
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
